// File: rtl/mc_main_controller_pkg.sv
// Shared constants and types for the multicycle main controller: opcodes, ALU op codes,
// mux select codes, FSM state encodings and the decoded control vector.
package mc_main_controller_pkg;

    // Opcode field values (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // alu_op codes understood by alu_decoder
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StAddiEx = 4'd9,
        StAddiWb = 4'd10,
        StJump   = 4'd11
    } state_e;

    // Per-state control vector. pc_write_rdy and ir_write are qualified by mem_ready,
    // branch by zero, in the top level.
    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       pc_write_rdy;
        logic       branch;
    } ctrl_t;

    localparam int unsigned CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Pure state -> control vector decode for the multicycle main controller.
module mc_ctrl_outdec
    import mc_main_controller_pkg::*;
(
    input  logic [3:0]        state,
    output logic [CTRL_W-1:0] ctrl
);

    ctrl_t c;

    // Decode each state's strobes; anything not set stays 0, unknown encodings give all 0.
    always_comb begin
        c = '0;
        case (state_e'(state))
            StFetch: begin
                c.mem_read     = 1'b1;
                c.ir_write     = 1'b1;
                c.alu_src_b    = SRC_B_FOUR;
                c.alu_op       = ALU_OP_ADD;
                c.pc_src       = PC_SRC_ALU;
                c.pc_write_rdy = 1'b1;
            end
            StDecode: begin
                c.alu_src_b = SRC_B_IMM_SH;  // branch target precompute
                c.alu_op    = ALU_OP_ADD;
            end
            StMemAdr, StAddiEx: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_IMM;
                c.alu_op    = ALU_OP_ADD;
            end
            StMemRd: begin
                c.iord     = 1'b1;
                c.mem_read = 1'b1;
            end
            StMemWb: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            StMemWr: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            StExec: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_REG;
                c.alu_op    = ALU_OP_FUNCT;
            end
            StAluWb: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            StBranch: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_REG;
                c.alu_op    = ALU_OP_SUB;
                c.pc_src    = PC_SRC_ALUOUT;
                c.branch    = 1'b1;
            end
            StAddiWb: begin
                c.reg_write = 1'b1;
            end
            StJump: begin
                c.pc_src   = PC_SRC_JUMP;
                c.pc_write = 1'b1;
            end
            default: c = '0;
        endcase
    end

    assign ctrl = c;

endmodule

// File: rtl/mc_main_controller.sv
// Multicycle main control FSM: sequences fetch/decode/execute/writeback over a shared
// ALU/memory datapath, waits on mem_ready and counts retired instructions.
module mc_main_controller
    import mc_main_controller_pkg::*;
#(
    parameter int unsigned OP_W  = 6,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             pc_en,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              retire;
    logic              illegal;
    logic [CTRL_W-1:0] ctrl_vec;
    ctrl_t             ctrl;

    mc_ctrl_outdec u_outdec (
        .state (state_q),
        .ctrl  (ctrl_vec)
    );

    assign ctrl = ctrl_t'(ctrl_vec);

    // Next-state selection, retire strobe on leaving a final state, illegal-opcode detect.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        illegal = 1'b0;
        case (state_q)
            StFetch:  if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_RTYPE:     state_d = StExec;
                    OP_BEQ:       state_d = StBranch;
                    OP_ADDI:      state_d = StAddiEx;
                    OP_J:         state_d = StJump;
                    default: begin
                        state_d = StFetch;
                        illegal = 1'b1;
                    end
                endcase
            end
            StMemAdr: begin
                if (opcode == OP_LW)      state_d = StMemRd;
                else if (opcode == OP_SW) state_d = StMemWr;
                else                      state_d = StFetch;
            end
            StMemRd:  if (mem_ready) state_d = StMemWb;
            StMemWr: begin
                if (mem_ready) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end
            end
            StExec:   state_d = StAluWb;
            StAddiEx: state_d = StAddiWb;
            StMemWb, StAluWb, StBranch, StAddiWb, StJump: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            default:  state_d = StFetch;
        endcase
    end

    // State and retired-instruction counter; reset abandons any instruction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (retire) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Output drive; reset forces every output low in the same cycle.
    always_comb begin
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        pc_en      = 1'b0;
        illegal_op = 1'b0;
        retired    = '0;
        if (!rst) begin
            iord       = ctrl.iord;
            mem_read   = ctrl.mem_read;
            mem_write  = ctrl.mem_write;
            ir_write   = ctrl.ir_write & mem_ready;
            reg_dst    = ctrl.reg_dst;
            mem_to_reg = ctrl.mem_to_reg;
            reg_write  = ctrl.reg_write;
            alu_src_a  = ctrl.alu_src_a;
            alu_src_b  = ctrl.alu_src_b;
            alu_op     = ctrl.alu_op;
            pc_src     = ctrl.pc_src;
            pc_en      = ctrl.pc_write | (ctrl.pc_write_rdy & mem_ready) | (ctrl.branch & zero);
            illegal_op = illegal;
            retired    = cnt_q;
        end
    end

endmodule

// File: tb/tb_mc_main_controller.sv
// Cycle-vector bench for mc_main_controller (CNT_W=4 so the counter wrap is reachable).
module tb_mc_main_controller;

    localparam int unsigned CW = 4;

    logic          clk, rst, zero, mem_ready;
    logic [5:0]    opcode;
    logic          iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic          alu_src_a, pc_en, illegal_op;
    logic [1:0]    alu_src_b, alu_op, pc_src;
    logic [CW-1:0] retired;

    mc_main_controller #(
        .OP_W  (6),
        .CNT_W (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .pc_en      (pc_en),
        .illegal_op (illegal_op),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {
        B_RST, B_FETCH, B_DECODE, B_MEMADR, B_MEMRD, B_MEMWB, B_MEMWR,
        B_EXEC, B_ALUWB, B_BRANCH, B_ADDIEX, B_ADDIWB, B_JUMP
    } bst_e;

    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_en;
        logic       illegal_op;
    } outs_t;

    typedef struct {
        logic          rst;
        logic [5:0]    op;
        logic          zero;
        logic          mr;
        bst_e          st;
        logic [CW-1:0] ret;
    } vec_t;

    typedef struct {
        outs_t         o;
        logic [CW-1:0] ret;
        int            idx;
        bst_e          st;
    } exp_t;

    vec_t          vecs[$];
    exp_t          sb[$];
    int            tests = 0;
    int            fails = 0;
    logic [CW-1:0] r = '0;

    localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011;
    localparam logic [5:0] T_BEQ = 6'b000100, T_ADDI = 6'b001000, T_J = 6'b000010;
    localparam logic [5:0] T_BAD = 6'b111111;

    // Expected outputs for a state, written from the state table of the controller.
    function automatic outs_t exp_out(bst_e st, logic mr, logic z, logic [5:0] op);
        outs_t o = '0;
        case (st)
            B_FETCH:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_en = mr; end
            B_DECODE: begin
                o.alu_src_b  = 2'b11;
                o.illegal_op = !(op inside {T_R, T_LW, T_SW, T_BEQ, T_ADDI, T_J});
            end
            B_MEMADR: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            B_MEMRD:  begin o.iord = 1; o.mem_read = 1; end
            B_MEMWB:  begin o.mem_to_reg = 1; o.reg_write = 1; end
            B_MEMWR:  begin o.iord = 1; o.mem_write = 1; end
            B_EXEC:   begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            B_ALUWB:  begin o.reg_dst = 1; o.reg_write = 1; end
            B_BRANCH: begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_src = 2'b01; o.pc_en = z; end
            B_ADDIEX: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            B_ADDIWB: begin o.reg_write = 1; end
            B_JUMP:   begin o.pc_src = 2'b10; o.pc_en = 1; end
            default:  o = '0;
        endcase
        return o;
    endfunction

    task automatic add(input logic rs, input logic [5:0] op, input logic z, input logic mr,
                       input bst_e st);
        vec_t v;
        v.rst = rs; v.op = op; v.zero = z; v.mr = mr; v.st = st;
        v.ret = rs ? '0 : r;
        vecs.push_back(v);
    endtask

    task automatic fetch_n(input logic [5:0] op, input int waits);
        for (int i = 0; i < waits; i++) add(0, op, 1, 0, B_FETCH);
        add(0, op, 1, 1, B_FETCH);
    endtask

    outs_t got;
    exp_t  e;

    initial begin
        rst = 1; opcode = '0; zero = 0; mem_ready = 1;

        // Reset held three cycles
        for (int i = 0; i < 3; i++) add(1, T_R, 1, 1, B_RST);
        r = '0;
        // R-type
        fetch_n(T_R, 0); add(0, T_R, 1, 1, B_DECODE); add(0, T_R, 1, 1, B_EXEC);
        add(0, T_R, 1, 1, B_ALUWB); r = r + 1'b1;
        // LW, 3 wait cycles in FETCH, 2 in MEMRD: 10 cycles total
        fetch_n(T_LW, 3); add(0, T_LW, 1, 1, B_DECODE); add(0, T_LW, 1, 1, B_MEMADR);
        add(0, T_LW, 1, 0, B_MEMRD); add(0, T_LW, 1, 0, B_MEMRD); add(0, T_LW, 1, 1, B_MEMRD);
        add(0, T_LW, 1, 1, B_MEMWB); r = r + 1'b1;
        // SW with one wait in MEMWR
        fetch_n(T_SW, 0); add(0, T_SW, 1, 1, B_DECODE); add(0, T_SW, 1, 1, B_MEMADR);
        add(0, T_SW, 1, 0, B_MEMWR); add(0, T_SW, 1, 1, B_MEMWR); r = r + 1'b1;
        // BEQ taken, then not taken
        fetch_n(T_BEQ, 0); add(0, T_BEQ, 1, 1, B_DECODE); add(0, T_BEQ, 1, 1, B_BRANCH);
        r = r + 1'b1;
        fetch_n(T_BEQ, 0); add(0, T_BEQ, 0, 1, B_DECODE); add(0, T_BEQ, 0, 1, B_BRANCH);
        r = r + 1'b1;
        // ADDI
        fetch_n(T_ADDI, 0); add(0, T_ADDI, 1, 1, B_DECODE); add(0, T_ADDI, 1, 1, B_ADDIEX);
        add(0, T_ADDI, 1, 1, B_ADDIWB); r = r + 1'b1;
        // Illegal opcode: no retire
        fetch_n(T_BAD, 0); add(0, T_BAD, 1, 1, B_DECODE);
        // 16 jumps: counter wraps through 15 -> 0 and lands back on the same value
        for (int i = 0; i < 16; i++) begin
            fetch_n(T_J, 0); add(0, T_J, 1, 1, B_DECODE); add(0, T_J, 1, 1, B_JUMP);
            r = r + 1'b1;
        end
        // Reset while SW is waiting in MEMWR: no write, back to FETCH, counter cleared
        fetch_n(T_SW, 0); add(0, T_SW, 1, 1, B_DECODE); add(0, T_SW, 1, 1, B_MEMADR);
        add(0, T_SW, 1, 0, B_MEMWR); add(1, T_SW, 1, 1, B_RST);
        r = '0;
        fetch_n(T_R, 1); add(0, T_R, 1, 1, B_DECODE);

        @(posedge clk); #1;
        for (int i = 0; i < vecs.size(); i++) begin
            rst       = vecs[i].rst;
            opcode    = vecs[i].op;
            zero      = vecs[i].zero;
            mem_ready = vecs[i].mr;
            e.o   = exp_out(vecs[i].st, vecs[i].mr, vecs[i].zero, vecs[i].op);
            e.ret = vecs[i].ret;
            e.idx = i;
            e.st  = vecs[i].st;
            sb.push_back(e);
            #3;
            e   = sb.pop_front();
            got = {iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                   alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal_op};
            tests++;
            if (got !== e.o) begin
                fails++;
                $display("FAIL vec%0d %s outputs: got %h required %h", e.idx, e.st.name(),
                         got, e.o);
            end
            tests++;
            if (retired !== e.ret) begin
                fails++;
                $display("FAIL vec%0d %s retired: got %0d required %0d", e.idx, e.st.name(),
                         retired, e.ret);
            end
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
